// File: rtl/mult_seq_ctrl_if.sv
// Request/response and partial-product-stage signals of the sequential multiplier.
// The master side is the CPU issue logic together with the combinational stage
// (it returns StageOut); the slave side is the sequencing controller.
interface mult_seq_ctrl_if;
    logic        Start;
    logic        Signed;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;
    logic        StageEn;
    logic [63:0] StageA;
    logic [3:0]  StageNum;
    logic        StageSign;
    logic [63:0] StageOut;

    modport master (
        output Start, Signed, OpA, OpB, StageOut,
        input  Busy, Done, Product, StageEn, StageA, StageNum, StageSign
    );

    modport slave (
        input  Start, Signed, OpA, OpB, StageOut,
        output Busy, Done, Product, StageEn, StageA, StageNum, StageSign
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the radix-16 partial-product stage.
// Works on operand magnitudes: one multiplier digit per ITER cycle, the stage
// returns StageA * StageNum combinationally, the sum is accumulated and the
// sign is restored in FIX. All outputs are registered.
module mult_seq_ctrl #(
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] stage_a_q, stage_a_d;     // multiplicand magnitude << 4*cnt
    logic [63:0] product_q, product_d;
    logic [31:0] breg_q, breg_d;           // multiplier magnitude >> 4*cnt
    logic [2:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        stage_en_q, stage_en_d;
    logic [3:0]  stage_num_q, stage_num_d;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        accept;
    logic        iter_last;

    // Operand magnitudes and the accept / last-digit decisions
    always_comb begin
        mag_a     = (bus.Signed && bus.OpA[31]) ? (~bus.OpA + 32'd1) : bus.OpA;
        mag_b     = (bus.Signed && bus.OpB[31]) ? (~bus.OpB + 32'd1) : bus.OpB;
        accept    = bus.Start && ((state_q == S_IDLE) || (state_q == S_DONE));
        // Early exit looks at the digits still to come, so the current
        // digit is always processed: at least one ITER cycle.
        iter_last = (cnt_q == 3'd7) || (EARLY_TERM && (breg_q[31:4] == 28'd0));
    end

    // Next-state and next-output logic; stage outputs are precomputed one
    // cycle ahead so they appear registered in the cycle they are used.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        breg_d      = breg_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        product_d   = product_q;
        stage_a_d   = 64'd0;
        stage_num_d = 4'd0;
        stage_en_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d     = S_ITER;
                    acc_d       = 64'd0;
                    cnt_d       = 3'd0;
                    breg_d      = mag_b;
                    neg_d       = bus.Signed && (bus.OpA[31] ^ bus.OpB[31]);
                    stage_a_d   = {32'd0, mag_a};
                    stage_num_d = mag_b[3:0];
                    stage_en_d  = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                acc_d  = acc_q + bus.StageOut;
                breg_d = breg_q >> 4;
                cnt_d  = cnt_q + 3'd1;
                busy_d = 1'b1;
                if (iter_last) begin
                    state_d = S_FIX;
                end else begin
                    stage_a_d   = stage_a_q << 4;
                    stage_num_d = breg_q[7:4];
                    stage_en_d  = 1'b1;
                end
            end
            S_FIX: begin
                product_d = neg_q ? (~acc_q + 64'd1) : acc_q;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            acc_q       <= 64'd0;
            stage_a_q   <= 64'd0;
            product_q   <= 64'd0;
            breg_q      <= 32'd0;
            cnt_q       <= 3'd0;
            neg_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_en_q  <= 1'b0;
            stage_num_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            stage_a_q   <= stage_a_d;
            product_q   <= product_d;
            breg_q      <= breg_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_en_q  <= stage_en_d;
            stage_num_q <= stage_num_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Product   = product_q;
    assign bus.StageEn   = stage_en_q;
    assign bus.StageA    = stage_a_q;
    assign bus.StageNum  = stage_num_q;
    assign bus.StageSign = 1'b0;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: one instance without and one with early termination,
// both fed the same requests, checked against an arithmetic reference model.
module tb_mult_seq_ctrl;
    logic clk;
    logic rst_n;
    int   test_cnt;
    int   fail_cnt;

    mult_seq_ctrl_if if0 ();
    mult_seq_ctrl_if if1 ();

    mult_seq_ctrl #(.EARLY_TERM(1'b0)) u_dut0 (.Clk(clk), .Reset(rst_n), .bus(if0.slave));
    mult_seq_ctrl #(.EARLY_TERM(1'b1)) u_dut1 (.Clk(clk), .Reset(rst_n), .bus(if1.slave));

    // Combinational partial-product stage model
    assign if0.StageOut = if0.StageA * {60'd0, if0.StageNum};
    assign if1.StageOut = if1.StageA * {60'd0, if1.StageNum};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Number of digit iterations: all 8, or up to the highest nonzero digit
    function automatic int ref_iters(input logic [31:0] b, input logic s, input bit et);
        logic [31:0] m;
        int n;
        if (!et) return 8;
        m = (s && b[31]) ? (32'd0 - b) : b;
        n = 1;
        for (int i = 0; i < 8; i++)
            if (((m >> (4 * i)) & 32'hF) != 32'd0) n = i + 1;
        return n;
    endfunction

    task automatic drive_req(input logic st, input logic [31:0] a, input logic [31:0] b, input logic s);
        if0.Start = st; if0.OpA = a; if0.OpB = b; if0.Signed = s;
        if1.Start = st; if1.OpA = a; if1.OpB = b; if1.Signed = s;
    endtask

    task automatic set_start(input logic st);
        if0.Start = st;
        if1.Start = st;
    endtask

    // Issue one request at the next edge (t0) and follow both instances to Done.
    // pulse_at: cycle index t0+k in which a stray Start is raised (0 = none).
    // Returns in the later Done cycle, so a following call chains without a bubble.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int pulse_at);
        logic [63:0] exp_p;
        int n0, n1, d0, d1, bc0, bc1, ec0, ec1, k, idle_bad;
        logic [63:0] p0, p1;
        bit got0, got1, sign_seen;
        exp_p = ref_prod(a, b, s);
        n0 = ref_iters(b, s, 1'b0);
        n1 = ref_iters(b, s, 1'b1);
        d0 = 99; d1 = 99; bc0 = 0; bc1 = 0; ec0 = 0; ec1 = 0; idle_bad = 0;
        p0 = '0; p1 = '0; got0 = 0; got1 = 0; sign_seen = 0;
        drive_req(1'b1, a, b, s);
        @(posedge clk);
        #1;
        // Scramble the operands: they were captured at accept
        drive_req(1'b0, $urandom, $urandom, 1'($urandom));
        k = 1;
        while (k <= 20 && !(got0 && got1)) begin
            sign_seen = sign_seen | if0.StageSign | if1.StageSign;
            if (!if0.StageEn && (if0.StageA != 64'd0 || if0.StageNum != 4'd0)) idle_bad++;
            if (!if1.StageEn && (if1.StageA != 64'd0 || if1.StageNum != 4'd0)) idle_bad++;
            if (!got0) begin
                if (if0.Busy) bc0++;
                if (if0.StageEn) ec0++;
                if (if0.Done) begin got0 = 1; d0 = k; p0 = if0.Product; end
            end
            if (!got1) begin
                if (if1.Busy) bc1++;
                if (if1.StageEn) ec1++;
                if (if1.Done) begin got1 = 1; d1 = k; p1 = if1.Product; end
            end
            if (!(got0 && got1)) begin
                set_start(k == pulse_at);
                @(posedge clk);
                #1;
                k++;
            end
        end
        $display("[TB] op a=0x%08h b=0x%08h s=%0d exp=0x%016h | et0 p=0x%016h done@%0d | et1 p=0x%016h done@%0d",
                 a, b, s, exp_p, p0, d0, p1, d1);
        check_val("et0_product",  p0, exp_p);
        check_val("et1_product",  p1, exp_p);
        check_val("et0_done_cyc", 64'(d0), 64'(n0 + 2));
        check_val("et1_done_cyc", 64'(d1), 64'(n1 + 2));
        check_val("et0_busy_cyc", 64'(bc0), 64'(n0 + 1));
        check_val("et1_busy_cyc", 64'(bc1), 64'(n1 + 1));
        check_val("et0_en_cyc",   64'(ec0), 64'(n0));
        check_val("et1_en_cyc",   64'(ec1), 64'(n1));
        check_val("stage_sign",   64'(sign_seen), 64'd0);
        check_val("stage_idle",   64'(idle_bad), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int dcount;
        logic [31:0] ra, rb;
        test_cnt = 0;
        fail_cnt = 0;
        rst_n = 1'b0;
        drive_req(1'b0, 32'd0, 32'd0, 1'b0);
        idle_cycles(3);

        // Reset state
        check_val("rst_busy",    {62'd0, if0.Busy, if1.Busy}, 64'd0);
        check_val("rst_done",    {62'd0, if0.Done, if1.Done}, 64'd0);
        check_val("rst_product", if0.Product | if1.Product, 64'd0);
        check_val("rst_stage",   if0.StageA | if1.StageA | {59'd0, if0.StageEn | if1.StageEn, if0.StageNum | if1.StageNum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        idle_cycles(1);
        run_op(32'hFFFFFFFD, 32'h00000007, 1'b1, 0);
        idle_cycles(2);
        run_op(32'h80000000, 32'h80000000, 1'b1, 0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 0);
        idle_cycles(1);
        run_op(32'h12345678, 32'h00000005, 1'b0, 0);
        idle_cycles(1);
        run_op(32'h9ABCDEF1, 32'h00000000, 1'b0, 0);
        idle_cycles(1);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 0);
        idle_cycles(1);

        // Stray Start while iterating is ignored
        run_op(32'h0BADF00D, 32'hF0000001, 1'b0, 3);
        idle_cycles(1);
        // Back-to-back: second request accepted in the Done cycle
        run_op(32'h01234567, 32'hF0000003, 1'b0, 0);
        run_op(32'hDEADBEEF, 32'h89ABCDEF, 1'b1, 0);
        idle_cycles(1);

        // Random requests with varied multiplier digit counts
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            run_op(ra, rb, 1'($urandom), 0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        // Reset in the middle of an operation
        drive_req(1'b1, 32'h11111111, 32'hFFFFFFFF, 1'b0);
        @(posedge clk);
        #1;
        set_start(1'b0);
        idle_cycles(3);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy",    {62'd0, if0.Busy, if1.Busy}, 64'd0);
        check_val("midrst_done",    {62'd0, if0.Done, if1.Done}, 64'd0);
        check_val("midrst_product", if0.Product | if1.Product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (if0.Done || if1.Done || if0.Busy || if1.Busy) dcount++;
        end
        $display("[TB] reset mid-op: activity cycles after release=%0d", dcount);
        check_val("midrst_no_done", 64'(dcount), 64'd0);
        check_val("midrst_prod_hold", if0.Product | if1.Product, 64'd0);

        // One more request to confirm recovery after reset
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
